// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
package usb_tx_pkg;

  // Field codes driven on field_sel; the shifter decodes these.
  typedef enum logic [2:0] {
    FLD_SYNC  = 3'd0,
    FLD_PID   = 3'd1,
    FLD_CRC5  = 3'd2,
    FLD_DATA  = 3'd3,
    FLD_CRC16 = 3'd4
  } field_t;

  typedef enum logic [1:0] {
    PKT_TOKEN = 2'd0,
    PKT_DATA  = 2'd1,
    PKT_HSK   = 2'd2
  } packet_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EOP,
    S_GAP,
    S_DONE
  } state_t;

  // Transaction modes selected by the transaction layer.
  localparam logic [1:0] MODE_TOKEN = 2'd0;
  localparam logic [1:0] MODE_DATA  = 2'd1;
  localparam logic [1:0] MODE_FULL  = 2'd2;
  localparam logic [1:0] MODE_HSK   = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  // On-wire PID byte: check nibble (complement) above the PID nibble.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_cycle_counter.sv
// Loadable down-counter used for both EOP and inter-packet gap timing.
module usb_tx_cycle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  // Final cycle of the current interval.
  assign last = (count == W'(1));

endmodule

// File: rtl/usb_tx_sequencer.sv
// Host-side USB OUT/SETUP transaction sequencer: token, data, handshake.
// Drives one field load at a time and waits for the shifter's done strobe.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter  int MAX_BYTES  = 8,
  parameter  int EOP_CYCLES = 2,
  parameter  int GAP_CYCLES = 2,
  localparam int CW = $clog2(MAX_BYTES + 1),
  localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [3:0]    tok_pid,
  input  logic [CW-1:0] byte_count,
  input  logic          abort,
  input  logic          toggle_clr,
  input  logic          shift_done,
  output logic          field_load,
  output logic [2:0]    field_sel,
  output logic [7:0]    tx_byte,
  output logic [IW-1:0] byte_idx,
  output logic          crc16_clear,
  output logic          eop_transmitting,
  output logic          idle_transmitting,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          data_toggle
);

  localparam int TMAX = (EOP_CYCLES > GAP_CYCLES) ? EOP_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state;
  packet_t       pkt;
  field_t        fld;
  logic [CW-1:0] count_r;
  logic [IW-1:0] idx;
  logic [1:0]    mode_r;
  logic [3:0]    pid_r;
  logic          abort_flag;

  logic [CW-1:0] count_in;
  field_t        nxt_fld;
  logic [IW-1:0] nxt_idx;
  logic          seq_end;
  logic [7:0]    nxt_byte;
  logic          last_byte;
  packet_t       nxt_pkt;
  logic          more_pkts;
  logic          cnt_load;
  logic          cnt_last;
  logic [TW-1:0] cnt_val;

  // Payloads longer than the buffer are truncated to MAX_BYTES.
  assign count_in  = (byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_count;
  assign last_byte = ((CW'(idx) + CW'(1)) == count_r);

  // Field ordering within the current packet; seq_end means the packet is complete.
  always_comb begin
    nxt_fld = fld;
    nxt_idx = idx;
    seq_end = 1'b0;
    case (fld)
      FLD_SYNC: nxt_fld = FLD_PID;
      FLD_PID: begin
        case (pkt)
          PKT_TOKEN: nxt_fld = FLD_CRC5;
          PKT_DATA: begin
            if (count_r == '0) begin
              nxt_fld = FLD_CRC16;
            end else begin
              nxt_fld = FLD_DATA;
              nxt_idx = '0;
            end
          end
          default: seq_end = 1'b1;
        endcase
      end
      FLD_DATA: begin
        if (last_byte) nxt_fld = FLD_CRC16;
        else           nxt_idx = idx + IW'(1);
      end
      default: seq_end = 1'b1;
    endcase
  end

  // Byte presented with the next load: only PID carries a byte from here (SYNC is fixed).
  always_comb begin
    nxt_byte = 8'h00;
    if (nxt_fld == FLD_PID) begin
      case (pkt)
        PKT_TOKEN: nxt_byte = pid_byte(pid_r);
        PKT_DATA:  nxt_byte = pid_byte(data_toggle ? PID_DATA1 : PID_DATA0);
        default:   nxt_byte = pid_byte(PID_ACK);
      endcase
    end
  end

  // Which packet follows the current one for the latched mode.
  always_comb begin
    more_pkts = 1'b0;
    nxt_pkt   = pkt;
    case (pkt)
      PKT_TOKEN: if (mode_r == MODE_DATA || mode_r == MODE_FULL) begin
        more_pkts = 1'b1;
        nxt_pkt   = PKT_DATA;
      end
      PKT_DATA: if (mode_r == MODE_FULL) begin
        more_pkts = 1'b1;
        nxt_pkt   = PKT_HSK;
      end
      default: more_pkts = 1'b0;
    endcase
  end

  // Counter holds EOP_CYCLES while outside EOP/GAP so the EOP interval starts
  // already loaded; the last EOP cycle reloads it with the gap length.
  assign cnt_load = !((state == S_EOP) || (state == S_GAP)) || ((state == S_EOP) && cnt_last);
  assign cnt_val  = (state == S_EOP) ? TW'(GAP_CYCLES) : TW'(EOP_CYCLES);

  usb_tx_cycle_counter #(.W(TW)) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= S_IDLE;
      pkt               <= PKT_TOKEN;
      fld               <= FLD_SYNC;
      count_r           <= '0;
      idx               <= '0;
      mode_r            <= MODE_TOKEN;
      pid_r             <= 4'h0;
      abort_flag        <= 1'b0;
      field_load        <= 1'b0;
      field_sel         <= FLD_SYNC;
      tx_byte           <= 8'h00;
      byte_idx          <= '0;
      crc16_clear       <= 1'b0;
      eop_transmitting  <= 1'b0;
      idle_transmitting <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
    end else begin
      field_load  <= 1'b0;
      crc16_clear <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_r            <= mode;
          pid_r             <= tok_pid;
          count_r           <= count_in;
          pkt               <= (mode == MODE_HSK) ? PKT_HSK : PKT_TOKEN;
          fld               <= FLD_SYNC;
          idx               <= '0;
          abort_flag        <= 1'b0;
          state             <= S_LOAD;
          field_load        <= 1'b1;
          field_sel         <= FLD_SYNC;
          tx_byte           <= SYNC_BYTE;
          byte_idx          <= '0;
          busy              <= 1'b1;
          idle_transmitting <= 1'b0;
        end
        S_LOAD, S_WAIT: begin
          if (abort || (state == S_WAIT && shift_done && seq_end)) begin
            // Packet finished or cut short: straight into EOP.
            abort_flag       <= abort_flag | abort;
            state            <= S_EOP;
            eop_transmitting <= 1'b1;
            field_sel        <= FLD_SYNC;
            tx_byte          <= 8'h00;
            byte_idx         <= '0;
          end else if (state == S_LOAD) begin
            state <= S_WAIT;
          end else if (shift_done) begin
            state      <= S_LOAD;
            fld        <= nxt_fld;
            idx        <= nxt_idx;
            field_load <= 1'b1;
            field_sel  <= nxt_fld;
            tx_byte    <= nxt_byte;
            byte_idx   <= (nxt_fld == FLD_DATA) ? nxt_idx : '0;
          end
        end
        S_EOP: begin
          if (abort) abort_flag <= 1'b1;
          if (cnt_last) begin
            state             <= S_GAP;
            eop_transmitting  <= 1'b0;
            idle_transmitting <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort) abort_flag <= 1'b1;
          if (cnt_last) begin
            idle_transmitting <= 1'b0;
            if (abort_flag || abort || !more_pkts) begin
              state   <= S_DONE;
              done    <= 1'b1;
              aborted <= abort_flag | abort;
            end else begin
              state       <= S_LOAD;
              pkt         <= nxt_pkt;
              fld         <= FLD_SYNC;
              idx         <= '0;
              field_load  <= 1'b1;
              field_sel   <= FLD_SYNC;
              tx_byte     <= SYNC_BYTE;
              byte_idx    <= '0;
              crc16_clear <= (nxt_pkt == PKT_DATA);
            end
          end
        end
        S_DONE: begin
          state             <= S_IDLE;
          busy              <= 1'b0;
          idle_transmitting <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data toggle: flips after a completed full transaction; clear always wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      data_toggle <= 1'b0;
    else if (toggle_clr)
      data_toggle <= 1'b0;
    else if (state == S_DONE && mode_r == MODE_FULL && !abort_flag)
      data_toggle <= ~data_toggle;
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed scoreboard bench for usb_tx_sequencer.
module tb_usb_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int MAXB = 8;
  localparam int EOPC = 3;
  localparam int GAPC = 4;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int IW   = $clog2(MAXB);

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [3:0]    tok_pid = 4'd0;
  logic [CW-1:0] byte_count = '0;
  logic          abort = 1'b0;
  logic          toggle_clr = 1'b0;
  logic          shift_done = 1'b0;
  logic          field_load;
  logic [2:0]    field_sel;
  logic [7:0]    tx_byte;
  logic [IW-1:0] byte_idx;
  logic          crc16_clear;
  logic          eop_transmitting;
  logic          idle_transmitting;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          data_toggle;

  typedef struct {
    logic [2:0]    fld;
    logic [7:0]    txb;
    logic [IW-1:0] idx;
  } load_t;

  load_t exp_q[$];
  logic  exp_abort_q[$];
  int    tests = 0;
  int    fails = 0;
  int    crc_cnt = 0;
  logic  resp_en = 1'b0;

  usb_tx_sequencer #(.MAX_BYTES(MAXB), .EOP_CYCLES(EOPC), .GAP_CYCLES(GAPC)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start             (start),
    .mode              (mode),
    .tok_pid           (tok_pid),
    .byte_count        (byte_count),
    .abort             (abort),
    .toggle_clr        (toggle_clr),
    .shift_done        (shift_done),
    .field_load        (field_load),
    .field_sel         (field_sel),
    .tx_byte           (tx_byte),
    .byte_idx          (byte_idx),
    .crc16_clear       (crc16_clear),
    .eop_transmitting  (eop_transmitting),
    .idle_transmitting (idle_transmitting),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .data_toggle       (data_toggle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] f, input logic [7:0] b, input int i);
    load_t e;
    e.fld = f;
    e.txb = b;
    e.idx = IW'(i);
    exp_q.push_back(e);
  endtask

  // Expected load stream for one full transaction.
  task automatic expect_txn(input logic [1:0] m, input logic [7:0] tok_byte, input int cnt,
                            input logic tog);
    int n;
    n = (cnt > MAXB) ? MAXB : cnt;
    if (m != 2'd3) begin
      push(3'd0, 8'h80, 0); push(3'd1, tok_byte, 0); push(3'd2, 8'h00, 0);
    end
    if (m == 2'd1 || m == 2'd2) begin
      push(3'd0, 8'h80, 0); push(3'd1, tog ? 8'h4B : 8'hC3, 0);
      for (int i = 0; i < n; i++) push(3'd3, 8'h00, i);
      push(3'd4, 8'h00, 0);
    end
    if (m == 2'd2 || m == 2'd3) begin
      push(3'd0, 8'h80, 0); push(3'd1, 8'hD2, 0);
    end
  endtask

  task automatic start_txn(input logic [1:0] m, input logic [3:0] pid, input int cnt);
    @(negedge clk);
    mode = m; tok_pid = pid; byte_count = CW'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_load", 32'(field_load), 32'd1);
    check("busy_at_load", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({field_load, field_sel, tx_byte, byte_idx, crc16_clear, eop_transmitting,
                idle_transmitting, busy, done, aborted, data_toggle});
  endfunction

  localparam logic [31:0] RST_OUTS = 32'({1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b0,
                                          1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

  // Shifter model: shift_done 4 cycles after each field load.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt != 0) begin
        cnt--;
        shift_done = (cnt == 0);
      end else begin
        shift_done = 1'b0;
      end
      if (field_load && resp_en) cnt = 3;
    end
  end

  // Monitor: pops expected loads/completions and times EOP/gap runs.
  initial begin : monitor
    int eop_run, gap_run;
    load_t e;
    logic ea;
    eop_run = 0;
    gap_run = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        eop_run = 0;
        gap_run = 0;
      end else begin
        if (field_load) begin
          if (exp_q.size() == 0) begin
            check("unexpected_load", 32'(field_load), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("field_sel", 32'(field_sel), 32'(e.fld));
            check("tx_byte", 32'(tx_byte), 32'(e.txb));
            if (e.fld == 3'd3) check("byte_idx", 32'(byte_idx), 32'(e.idx));
          end
        end
        if (crc16_clear) crc_cnt++;
        if (done) begin
          if (exp_abort_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            ea = exp_abort_q.pop_front();
            check("aborted", 32'(aborted), 32'(ea));
          end
        end
        if (eop_transmitting) eop_run++;
        else if (eop_run != 0) begin
          check("eop_len", 32'(eop_run), 32'(EOPC));
          eop_run = 0;
        end
        if (busy && idle_transmitting) gap_run++;
        else if (gap_run != 0) begin
          check("gap_len", 32'(gap_run), 32'(GAPC));
          gap_run = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, c;
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), RST_OUTS);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", outs(), RST_OUTS);

    // Full transaction, DATA0, toggle flips to 1
    c0 = crc_cnt;
    expect_txn(2'd2, 8'hE1, 3, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd2, 4'b0001, 3);
    wait_done(600);
    @(negedge clk);
    check("toggle_t1", 32'(data_toggle), 32'd1);
    check("crc_t1", 32'(crc_cnt - c0), 32'd1);
    check("q_t1", 32'(exp_q.size()), 32'd0);
    check("idle_after_t1", 32'({busy, idle_transmitting}), 32'b01);

    // Repeat: DATA1, toggle back to 0
    expect_txn(2'd2, 8'hE1, 3, 1'b1); exp_abort_q.push_back(1'b0);
    start_txn(2'd2, 4'b0001, 3);
    wait_done(600);
    @(negedge clk);
    check("toggle_t2", 32'(data_toggle), 32'd0);
    check("q_t2", 32'(exp_q.size()), 32'd0);

    // Bring toggle to 1 then clear it
    expect_txn(2'd2, 8'hE1, 1, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd2, 4'b0001, 1);
    wait_done(600);
    @(negedge clk);
    check("toggle_t3", 32'(data_toggle), 32'd1);
    toggle_clr = 1'b1;
    @(negedge clk);
    toggle_clr = 1'b0;
    check("toggle_clr", 32'(data_toggle), 32'd0);

    // Zero-length data packet
    c0 = crc_cnt;
    expect_txn(2'd1, 8'hE1, 0, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd1, 4'b0001, 0);
    wait_done(600);
    @(negedge clk);
    check("crc_zero_len", 32'(crc_cnt - c0), 32'd1);
    check("toggle_mode1", 32'(data_toggle), 32'd0);
    check("q_zero_len", 32'(exp_q.size()), 32'd0);

    // Oversized count is truncated to MAX_BYTES
    expect_txn(2'd1, 8'hE1, 15, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd1, 4'b0001, 15);
    wait_done(900);
    @(negedge clk);
    check("q_clamp", 32'(exp_q.size()), 32'd0);

    // Abort in the WAIT of the second data byte
    push(3'd0, 8'h80, 0); push(3'd1, 8'hE1, 0); push(3'd2, 8'h00, 0);
    push(3'd0, 8'h80, 0); push(3'd1, 8'hC3, 0); push(3'd3, 8'h00, 0); push(3'd3, 8'h00, 1);
    exp_abort_q.push_back(1'b1);
    start_txn(2'd2, 4'b0001, 3);
    c = 0;
    while (!(field_load && field_sel == 3'd3 && byte_idx == IW'(1)) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("abort_reach", 32'(field_load), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("eop_after_abort", 32'(eop_transmitting), 32'd1);
    wait_done(100);
    @(negedge clk);
    check("toggle_abort", 32'(data_toggle), 32'd0);
    repeat (20) @(negedge clk);
    check("q_abort", 32'(exp_q.size()), 32'd0);

    // Token only; inputs change and start re-pulses while busy
    expect_txn(2'd0, 8'h2D, 0, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd0, 4'b1101, 0);
    mode = 2'd3; tok_pid = 4'd0; byte_count = CW'(5);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    repeat (30) @(negedge clk);
    check("q_token", 32'(exp_q.size()), 32'd0);
    check("busy_token", 32'(busy), 32'd0);

    // Handshake only
    expect_txn(2'd3, 8'h00, 0, 1'b0); exp_abort_q.push_back(1'b0);
    start_txn(2'd3, 4'b0001, 0);
    wait_done(300);
    @(negedge clk);
    check("toggle_hsk", 32'(data_toggle), 32'd0);
    check("q_hsk", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of WAIT
    expect_txn(2'd2, 8'hE1, 3, 1'b0);
    start_txn(2'd2, 4'b0001, 3);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_reset_outs", outs(), RST_OUTS);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_outs", outs(), RST_OUTS);
    check("done_q_empty", 32'(exp_abort_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
